// File: rtl/wb_dmem_line_responder_pkg.sv
// Shared dcache/memory-side types: responder state encoding and line geometry.
package wb_dmem_line_responder_pkg;

    localparam int DMEM_LINE_WORDS  = 4;
    localparam int DMEM_OFFSET_BITS = $clog2(DMEM_LINE_WORDS);

    // Line responder sequencing states
    typedef enum logic [2:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_ISSUE,
        DMEM_DRAIN,
        DMEM_ACK
    } type_dmem_resp_states_e;

endpackage

// File: rtl/wb_dmem_line_responder_dmem_beat_counter.sv
// Beat sequencing for the line responder: wait-state countdown, wrapping
// word-offset counter and last-beat detection.
module dmem_beat_counter #(
    parameter int  LINE_WORDS  = 4,
    parameter int  WAIT_CYCLES = 0,
    localparam int OFF_W       = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [OFF_W-1:0] start_off,
    input  logic             wait_en,
    input  logic             beat_en,
    output logic [OFF_W-1:0] offset,
    output logic             wait_done,
    output logic             last_beat
);

    // Countdown reaches 0 on the last WAIT cycle, so WAIT lasts WAIT_CYCLES cycles
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [3:0]       wait_cnt;
    logic [OFF_W-1:0] beat_cnt;

    // Load on request accept; offset wraps naturally at the power-of-two line size
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            offset   <= '0;
            beat_cnt <= '0;
        end else if (load) begin
            wait_cnt <= WAIT_LOAD;
            offset   <= start_off;
            beat_cnt <= '0;
        end else begin
            if (wait_en && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (beat_en) begin
                offset   <= offset + OFF_W'(1);
                beat_cnt <= beat_cnt + OFF_W'(1);
            end
        end
    end

    assign wait_done = (wait_cnt == 4'd0);
    assign last_beat = (beat_cnt == OFF_W'(LINE_WORDS - 1));

endmodule

// File: rtl/wb_dmem_line_responder.sv
// Memory-side responder for dcache line fills / write-backs. Serialises a
// line into word beats on a single-port synchronous data memory.
// Build option DMEM_CWF_EN: critical word first (start at the requested word).
module wb_dmem_line_responder
    import wb_dmem_line_responder_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int LINE_WORDS  = DMEM_LINE_WORDS,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dcache2mem_req_i,
    input  logic                         dcache2mem_wr_i,
    input  logic                         dcache2mem_kill_i,
    input  logic [ADDR_W-1:0]            dcache2mem_addr_i,
    input  logic [LINE_WORDS*WORD_W-1:0] dcache2mem_data_i,
    output logic                         mem2dcache_ack_o,
    output logic [LINE_WORDS*WORD_W-1:0] mem2dcache_data_o,
    output logic                         dmem_req_o,
    output logic                         dmem_we_o,
    output logic [ADDR_W-1:0]            dmem_addr_o,
    output logic [WORD_W-1:0]            dmem_wdata_o,
    input  logic [WORD_W-1:0]            dmem_rdata_i
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int LB_BITS = OFF_W + 2;

    type_dmem_resp_states_e state, nxt;

    logic                               wr_q;
    logic [ADDR_W-1:0]                  base_q;
    logic [LINE_WORDS-1:0][WORD_W-1:0]  wline_q;
    logic [LINE_WORDS-1:0][WORD_W-1:0]  line_buf;
    logic                               rd_pend;
    logic [OFF_W-1:0]                   rd_off;
    logic [OFF_W-1:0]                   offset;
    logic [OFF_W-1:0]                   start_off;
    logic                               accept;
    logic                               in_issue;
    logic                               wait_done;
    logic                               last_beat;
    logic                               unused_addr_lsbs;

    assign accept   = (state == DMEM_IDLE) && dcache2mem_req_i && !dcache2mem_kill_i;
    assign in_issue = (state == DMEM_ISSUE);

`ifdef DMEM_CWF_EN
    assign start_off = dcache2mem_addr_i[LB_BITS-1:2];
`else
    assign start_off = '0;
`endif

    // Byte/word offset bits only feed the start offset in some builds
    assign unused_addr_lsbs = ^dcache2mem_addr_i[LB_BITS-1:0];

    dmem_beat_counter #(
        .LINE_WORDS  (LINE_WORDS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_beat_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .start_off (start_off),
        .wait_en   (state == DMEM_WAIT),
        .beat_en   (dmem_req_o),
        .offset    (offset),
        .wait_done (wait_done),
        .last_beat (last_beat)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= DMEM_IDLE;
        else     state <= nxt;
    end

    // Next state; kill overrides every transition including the ack
    always_comb begin
        nxt = state;
        case (state)
            DMEM_IDLE:  if (accept) nxt = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_ISSUE;
            DMEM_WAIT:  if (wait_done) nxt = DMEM_ISSUE;
            DMEM_ISSUE: if (last_beat) nxt = wr_q ? DMEM_ACK : DMEM_DRAIN;
            DMEM_DRAIN: nxt = DMEM_ACK;
            DMEM_ACK:   nxt = DMEM_IDLE;
            default:    nxt = DMEM_IDLE;
        endcase
        if (dcache2mem_kill_i) nxt = DMEM_IDLE;
    end

    // Latch the request: direction, line base and (for write-backs) the line
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            base_q  <= '0;
            wline_q <= '0;
        end else if (accept) begin
            wr_q   <= dcache2mem_wr_i;
            base_q <= {dcache2mem_addr_i[ADDR_W-1:LB_BITS], LB_BITS'(0)};
            if (dcache2mem_wr_i) wline_q <= dcache2mem_data_i;
        end
    end

    // Read data arrives one cycle after its beat; file it under that beat's offset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            rd_off   <= '0;
            line_buf <= '0;
        end else begin
            rd_pend <= dmem_req_o && !wr_q;
            rd_off  <= offset;
            if (rd_pend) line_buf[rd_off] <= dmem_rdata_i;
        end
    end

    assign dmem_req_o        = in_issue && !dcache2mem_kill_i;
    assign dmem_we_o         = dmem_req_o && wr_q;
    assign dmem_addr_o       = in_issue ? base_q + (ADDR_W'(offset) << 2) : '0;
    assign dmem_wdata_o      = (in_issue && wr_q) ? wline_q[offset] : '0;
    assign mem2dcache_ack_o  = (state == DMEM_ACK) && !dcache2mem_kill_i;
    assign mem2dcache_data_o = line_buf;

endmodule

// File: doc/wb_dmem_line_responder.md
# wb_dmem_line_responder

Memory-side responder for the write-back data cache's line-fill/write-back protocol. It accepts `dcache2mem_req`/`wr`/`kill` from the dcache controller and serialises each line transfer into word beats on a synchronous single-port SRAM-style data memory. For reads it assembles the line and returns it with a one-cycle `mem2dcache_ack`. It sits between the dcache controller/datapath and the data memory macro.

## Interface
- `ADDR_W`, 32, byte-address width
- `WORD_W`, 32, memory word width; fixed at 32, with byte offset bits [1:0]
- `LINE_WORDS`, 4, words per cache line; a power of two, at least 2
- `WAIT_CYCLES`, 0, idle cycles inserted before the first beat (0..15)

Ports:
- `clk` in 1: single clock; all logic on its rising edge
- `rst` in 1: reset; synchronous, active-high
- `dcache2mem_req_i` in 1: transfer request; held high by the cache until ack
- `dcache2mem_wr_i` in 1: 1 = line write-back, 0 = line fill
- `dcache2mem_kill_i` in 1: abort the current or pending transfer
- `dcache2mem_addr_i` in ADDR_W: byte address inside the target line
- `dcache2mem_data_i` in LINE_WORDS*WORD_W: write-back line; word k sits at bits [k*32 +: 32]
- `mem2dcache_ack_o` out 1: one-cycle completion pulse
- `mem2dcache_data_o` out LINE_WORDS*WORD_W: filled line, same word layout
- `dmem_req_o` out 1: beat strobe
- `dmem_we_o` out 1: beat is a write
- `dmem_addr_o` out ADDR_W: word byte address; bits [1:0] are always 0
- `dmem_wdata_o` out WORD_W: write beat data
- `dmem_rdata_i` in WORD_W: read data, valid the cycle after a read beat

## Operation
- States: IDLE, WAIT, ISSUE, DRAIN, ACK.
- **IDLE:**
  - When `req & ~kill`: latch `wr`, the line base (addr with the low log2(LINE_WORDS)+2 bits cleared), the start offset and, for writes, the full write line.
  - Next state is WAIT if WAIT_CYCLES > 0, else ISSUE.
- **WAIT:** counts WAIT_CYCLES cycles, then goes to ISSUE.
- **ISSUE:**
  - Issues one beat per cycle, LINE_WORDS consecutive cycles.
  - The beat offset counter increments modulo LINE_WORDS (wrap-around).
  - `dmem_addr_o` = base + offset*4.
  - Writes drive `dmem_wdata_o` = latched word[offset].
  - Reads: each returned word is written into line-buffer slot [offset of the previous beat], regardless of issue order.
  - After the last beat, writes go to ACK and reads go to DRAIN.
- **DRAIN:** captures the final read word, then goes to ACK.
- **ACK:**
  - `mem2dcache_ack_o` = 1 for exactly one cycle, then IDLE.
  - `req` in this cycle is ignored. The cache may already present its next request, e.g. fill after write-back; it is sampled in IDLE on the following cycle.
- **Kill:**
  - `dcache2mem_kill_i` in any state returns to IDLE next cycle, with no ack.
  - `dmem_req_o` is forced to 0 combinationally in the kill cycle.
  - Already-issued write beats are not rolled back.
  - Kill wins over a simultaneous `req` in IDLE and over ack in ACK; ack is suppressed.
- **Line buffer:** `mem2dcache_data_o` is a register. It changes only on read captures and holds its value after ack.
- **Reset** (`rst` high at an edge) clears all of the following, from any state, mid-transfer included:
  - state goes to IDLE;
  - all outputs go to 0, including `mem2dcache_data_o`;
  - counters are cleared.

## Timing
- A request is sampled at edge 0 in IDLE. With WAIT_CYCLES = W:
  - beats are issued in cycles W+1 .. W+LINE_WORDS;
  - read ack comes in cycle W+LINE_WORDS+2;
  - write ack comes in cycle W+LINE_WORDS+1.
- Defaults: read ack at cycle 6, write ack at cycle 5.
- The minimum gap between ack and the next accepted request is 1 cycle (the IDLE cycle).
- `dmem_*` outputs are combinational from state and counters. `mem2dcache_ack_o` is decoded from the ACK state.

## Configuration
- `DMEM_CWF_EN` defined: critical word first. The first beat offset is addr[log2(LINE_WORDS)+1:2], and later beats wrap modulo LINE_WORDS.
- Undefined: the first beat offset is always 0 and beats run in ascending order.
- The line layout of `mem2dcache_data_o` is identical in both builds; only beat order differs.

## Structure
- The shared cache package holds:
  - the `type_dmem_resp_states_e` enum;
  - the `DMEM_LINE_WORDS` and `DMEM_OFFSET_BITS` constants, alongside the existing dcache types.
- One natural sub-module: `dmem_beat_counter`, covering the wait countdown, the wrapping offset counter and last-beat detection.
- Line assembly, the state machine and the kill handling stay in the top.

## Test plan
- **Read fill:** memory word at byte address 0x100+4k holds 0xA0+k; req, wr=0, addr 0x108 → beats at addresses 0x100, 0x104, 0x108, 0x10C (CWF build: 0x108, 0x10C, 0x100, 0x104); ack at cycle 6; data_o = {0xA3, 0xA2, 0xA1, 0xA0}.
- **Write-back:** req, wr=1, addr 0x200, line {4, 3, 2, 1} → four write beats writing 1..4 to 0x200..0x20C; ack at cycle 5; no read capture.
- **Back-to-back:** write-back ack followed by a held req with wr=0 → exactly one IDLE cycle, then a fill starts; exactly two acks in total.
- **Kill:** kill asserted during the 2nd ISSUE cycle → `dmem_req_o` is 0 that cycle; IDLE next cycle; no ack; a later read completes normally.
- **Wait states:** WAIT_CYCLES=3 read → first beat in cycle 4; ack at cycle 9.
- **Reset:** `rst` pulsed during DRAIN → all outputs 0 next cycle; no ack.
